// File: rtl/oai222_arc_pkg.sv
// Shared constants, state encoding and arc-vector helpers for the OAI222 arc tester.
// Vector bit p drives pin p: bit0=A1, bit1=A2, bit2=B1, bit3=B2, bit4=C1, bit5=C2.
package oai222_arc_pkg;

    localparam logic [2:0] PIN_A1 = 3'd0;
    localparam logic [2:0] PIN_A2 = 3'd1;
    localparam logic [2:0] PIN_B1 = 3'd2;
    localparam logic [2:0] PIN_B2 = 3'd3;
    localparam logic [2:0] PIN_C1 = 3'd4;
    localparam logic [2:0] PIN_C2 = 3'd5;

    localparam int NUM_PINS   = 6;
    localparam int NUM_CONDS  = 9;
    localparam int NUM_ARCS   = 54;
    localparam int NUM_PHASES = 3;

    // Side-condition code -> {x1,x2}; code n lives in bits [2n+1:2n].
    localparam logic [5:0] CODE_LUT = {2'b11, 2'b10, 2'b01};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [5:0] vec_of(input logic [2:0] pin,
                                          input logic [3:0] cond,
                                          input logic [1:0] phase);
        logic [5:0] v;
        logic [1:0] og0, og1;
        logic [1:0] c0, c1;
        logic [1:0] w0, w1;
        v = '0;
        case (pin[2:1])
            2'd0:    begin og0 = 2'd1; og1 = 2'd2; end
            2'd1:    begin og0 = 2'd0; og1 = 2'd2; end
            default: begin og0 = 2'd0; og1 = 2'd1; end
        endcase
        c0 = 2'(cond / 4'd3);
        c1 = 2'(cond % 4'd3);
        w0 = CODE_LUT[{c0, 1'b0} +: 2];
        w1 = CODE_LUT[{c1, 1'b0} +: 2];
        v[{og0, 1'b0}] = w0[1];
        v[{og0, 1'b1}] = w0[0];
        v[{og1, 1'b0}] = w1[1];
        v[{og1, 1'b1}] = w1[0];
        // Sibling stays 0 so the pin alone opens/closes its group.
        v[pin] = (phase == 2'd1);
        return v;
    endfunction

    function automatic logic exp_of(input logic [1:0] phase);
        return (phase != 2'd1);
    endfunction

endpackage

// File: rtl/oai222_arc_tester_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
// Latency: 2 clk. No backpressure.
// Reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/oai222_arc_tester.sv
// Walks all 54 OAI222 arcs x 3 phases, checking ZN after a settle time.
// Latency: 162*(SETTLE_CYCLES+1) clk from START to DONE. START ignored while BUSY.
module oai222_arc_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             B1,
    output logic             B2,
    output logic             C1,
    output logic             C2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [5:0]       FAIL_ARC,
    output logic [1:0]       FAIL_PHASE
);
    import oai222_arc_pkg::*;

    if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 3..255");
    end

    state_t     state, state_nxt;
    logic [7:0] settle_cnt;
    logic [2:0] pin, pin_n;
    logic [3:0] cond, cond_n;
    logic [1:0] phase, phase_n;
    logic [5:0] vec;
    logic [5:0] arc_idx;
    logic       zn_s;
    logic       start_run, check_now, last_check, mismatch;
    logic [ERR_W-1:0] err_nxt;

    sync2 u_zn_sync (
        .clk (CLK),
        .rst (RST),
        .d   (ZN),
        .q   (zn_s)
    );

    assign {C2, C1, B2, B1, A2, A1} = vec;
    assign arc_idx = {pin, 3'b000} + {3'b000, pin} + {2'b00, cond};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= oai222_arc_pkg::IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_run  = 1'b0;
        check_now  = 1'b0;
        last_check = 1'b0;
        mismatch   = 1'b0;
        case (state)
            oai222_arc_pkg::RUN: begin
                if (settle_cnt == 8'd0) begin
                    check_now  = 1'b1;
                    mismatch   = (zn_s != exp_of(phase));
                    last_check = (pin == PIN_C2) && (cond == 4'(NUM_CONDS - 1))
                                 && (phase == 2'(NUM_PHASES - 1));
                    if (last_check) state_nxt = oai222_arc_pkg::DONE;
                end
            end
            default: begin
                if (START) begin
                    start_run = 1'b1;
                    state_nxt = oai222_arc_pkg::RUN;
                end
            end
        endcase
    end

    always_comb begin
        pin_n   = pin;
        cond_n  = cond;
        phase_n = phase + 2'd1;
        if (phase == 2'(NUM_PHASES - 1)) begin
            phase_n = 2'd0;
            if (cond == 4'(NUM_CONDS - 1)) begin
                cond_n = 4'd0;
                pin_n  = pin + 3'd1;
            end else begin
                cond_n = cond + 4'd1;
            end
        end
        err_nxt = ERR_CNT;
        if (mismatch && (ERR_CNT != {ERR_W{1'b1}})) err_nxt = ERR_CNT + ERR_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_cnt <= '0;
            pin        <= '0;
            cond       <= '0;
            phase      <= '0;
            vec        <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_ARC   <= '0;
            FAIL_PHASE <= '0;
        end else if (start_run) begin
            settle_cnt <= 8'(SETTLE_CYCLES);
            pin        <= '0;
            cond       <= '0;
            phase      <= '0;
            vec        <= vec_of(3'd0, 4'd0, 2'd0);
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_ARC   <= '0;
            FAIL_PHASE <= '0;
        end else if (check_now) begin
            ERR_CNT <= err_nxt;
            // Only the first mismatch is captured; later ones just count.
            if (mismatch && !FAIL_VALID) begin
                FAIL_VALID <= 1'b1;
                FAIL_ARC   <= arc_idx;
                FAIL_PHASE <= phase;
            end
            if (last_check) begin
                vec  <= '0;
                BUSY <= 1'b0;
                DONE <= 1'b1;
                PASS <= (err_nxt == '0);
            end else begin
                settle_cnt <= 8'(SETTLE_CYCLES);
                pin        <= pin_n;
                cond       <= cond_n;
                phase      <= phase_n;
                vec        <= vec_of(pin_n, cond_n, phase_n);
            end
        end else if (state == oai222_arc_pkg::RUN) begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_oai222_arc_tester.sv
// Randomised bench for oai222_arc_tester: behavioural cell models on ZN, expected
// results derived by enumerating all 162 checks from the arc rules.
module tb_oai222_arc_tester;

    localparam int SETTLE = 4;
    localparam int PER    = SETTLE + 1;
    localparam int CHECKS = 162;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       zn;
    logic       a1, a2, b1, b2, c1, c2;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_cnt;
    logic [5:0] fail_arc;
    logic [1:0] fail_phase;
    logic [5:0] dvec;
    logic [5:0] tv = '0;
    int         fault_mode = 0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    oai222_arc_tester #(.SETTLE_CYCLES(SETTLE), .ERR_W(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .ZN(zn),
        .A1(a1), .A2(a2), .B1(b1), .B2(b2), .C1(c1), .C2(c2),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
        .FAIL_VALID(fail_valid), .FAIL_ARC(fail_arc), .FAIL_PHASE(fail_phase)
    );

    assign dvec = {c2, c1, b2, b1, a2, a1};

    // Cell models: 0 ideal, 1 stuck-0, 2 stuck-1, 3 ignores B2, 4 ideal inverted on vector t.
    function automatic logic cell_out(input int mode, input logic [5:0] v, input logic [5:0] t);
        logic a, b, c, ideal;
        a = v[0] | v[1];
        b = v[2] | v[3];
        c = v[4] | v[5];
        ideal = !(a & b & c);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !(a & v[2] & c);
            4:       return ideal ^ (v == t);
            default: return ideal;
        endcase
    endfunction

    assign zn = cell_out(fault_mode, dvec, tv);

    // Drive vector of check number n (arc = n/3, phase = n%3).
    function automatic logic [5:0] ref_vec(input int n);
        logic [5:0] v;
        int arc, ph, pin, cnd, grp, k, cd;
        int others[2];
        v   = '0;
        arc = n / 3;
        ph  = n % 3;
        pin = arc / 9;
        cnd = arc % 9;
        grp = pin / 2;
        k   = 0;
        for (int g = 0; g < 3; g++) begin
            if (g != grp) begin
                others[k] = g;
                k++;
            end
        end
        for (int j = 0; j < 2; j++) begin
            cd = (j == 0) ? cnd / 3 : cnd % 3;
            v[2 * others[j]]     = (cd != 1) ? 1'b0 : 1'b1;
            v[2 * others[j]]     = (cd != 0);
            v[2 * others[j] + 1] = (cd != 1);
        end
        v[pin] = (ph == 1);
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_run(input int mode, input bit repulse);
        int  exp_err, exp_arc, exp_ph, done_k;
        bit  exp_fv;
        logic obs;
        fault_mode = mode;
        exp_err = 0; exp_arc = 0; exp_ph = 0; exp_fv = 0;
        for (int n = 0; n < CHECKS; n++) begin
            obs = cell_out(mode, ref_vec(n), tv);
            if (obs != ((n % 3) != 1)) begin
                if (!exp_fv) begin
                    exp_fv  = 1;
                    exp_arc = n / 3;
                    exp_ph  = n % 3;
                end
                exp_err++;
            end
        end
        if (exp_err > 255) exp_err = 255;

        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_pass", pass, 0);
        chk("start_err", err_cnt, 0);
        chk("start_fvalid", fail_valid, 0);
        chk("start_vec", dvec, ref_vec(0));

        done_k = -1;
        for (int k = 1; k <= 1000 && done_k < 0; k++) begin
            @(posedge clk);
            #1;
            if (repulse) start = (k == 100);
            if (k % PER == 0 && k < CHECKS * PER) chk("vec", dvec, ref_vec(k / PER));
            if (k == 40 * PER) chk("arc13_ph1_vec", dvec, 6'b010110);
            if (k == CHECKS * PER - 1) chk("busy_last", busy, 1);
            if (done) done_k = k;
        end
        start = 1'b0;
        if (done_k < 0) chk("done_timeout", 0, 1);
        chk("done_edge", done_k, CHECKS * PER);
        chk("end_busy", busy, 0);
        chk("end_vec", dvec, 0);
        chk("err_cnt", err_cnt, exp_err);
        chk("pass", pass, (exp_err == 0) ? 1 : 0);
        chk("fail_valid", fail_valid, exp_fv);
        if (exp_fv) begin
            chk("fail_arc", fail_arc, exp_arc);
            chk("fail_phase", fail_phase, exp_ph);
        end
    endtask

    initial begin
        #2;
        chk("rst_vec", dvec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fvalid", fail_valid, 0);
        chk("rst_farc", fail_arc, 0);
        chk("rst_fphase", fail_phase, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_run(0, 1'b0);
        do_run(1, 1'b0);
        do_run(0, 1'b1);
        do_run(2, 1'b0);
        do_run(3, 1'b0);
        for (int r = 0; r < 2; r++) begin
            tv = ref_vec($urandom_range(0, CHECKS - 1));
            do_run(4, 1'b0);
        end

        fault_mode = 1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_vec", dvec, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_fvalid", fail_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        do_run(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/oai222_arc_tester.md
Name: oai222_arc_tester

Overview:
On-chip characterisation sequencer that drives the six inputs of one OAI222 cell under test and reads back its ZN output. It walks every sensitised timing arc, 6 pins × 9 side conditions, exactly as the cell's conditional arcs are enumerated. It checks ZN against ZN = !((A1|A2)&(B1|B2)&(C1|C2)) after a programmable settle time. It sits in the standard-cell test-structure tile, next to the cell instance, and is controlled by a simple start/done handshake from the test controller.

Parameters:
SETTLE_CYCLES, 4, clocks between driving a vector and sampling ZN; legal range 3..255; elaboration error outside that range.
ERR_W, 8, width of the saturating error counter.

Ports:
CLK  input  1  single clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  level-sampled; starts a run when sampled high in IDLE or DONE.
ZN  input  1  output of the cell under test; asynchronous, synchronised internally.
A1  output  1  drive to cell input A1.
A2  output  1  drive to cell input A2.
B1  output  1  drive to cell input B1.
B2  output  1  drive to cell input B2.
C1  output  1  drive to cell input C1.
C2  output  1  drive to cell input C2.
BUSY  output  1  run in progress.
DONE  output  1  run complete; sticky until the next START or RST.
PASS  output  1  valid when DONE; 1 if ERR_CNT==0.
ERR_CNT  output  ERR_W  mismatch count, saturates at all-ones.
FAIL_VALID  output  1  at least one mismatch recorded.
FAIL_ARC  output  6  arc index of the first mismatch, = pin*9+cond.
FAIL_PHASE  output  2  phase of the first mismatch.

Behaviour:
- Reset (async, RST=1): all of A1..C2=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VALID=0, FAIL_ARC=0, FAIL_PHASE=0, FSM=IDLE, synchroniser flops=0.
- Pin order: pin 0..5 = A1,A2,B1,B2,C1,C2. Pin p belongs to group g=p/2; its sibling in the same group is held at 0.
- Side condition cond 0..8 sets the two other groups, in ascending group order.
  - First other group takes code cond/3; second other group takes code cond%3.
  - Code map: 0→(x1,x2)=(0,1); 1→(1,0); 2→(1,1).
- Arc order: pin-major, cond-minor; 54 arcs.
- Each arc has 3 phases, 162 checks in total:
  - phase 0: pin=0, expect ZN=1.
  - phase 1: pin=1, expect ZN=0.
  - phase 2: pin=0, expect ZN=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + START=1 at an edge: clear ERR_CNT, FAIL_*, DONE and PASS; drive arc 0 phase 0 vector; BUSY=1; go to RUN.
  - RUN: each phase lasts SETTLE_CYCLES+1 edges. The settle counter is loaded at vector drive.
  - At the last edge of a phase: compare the synchronised ZN with the expected value, and on that same edge drive the next phase's vector.
  - After check 162: go to DONE, DONE=1, BUSY=0, PASS=(ERR_CNT_next==0), and drive A1..C2 to 0.
  - DONE rises exactly 162*(SETTLE_CYCLES+1) edges after the START edge.
- START is ignored while BUSY. START held high in DONE restarts immediately.
- ZN passes through a 2-flop synchroniser before compare. SETTLE_CYCLES≥3 guarantees the sampled value reflects the current vector.
- On a mismatch: ERR_CNT increments, saturating at 2^ERR_W−1.
  - If FAIL_VALID=0: capture FAIL_ARC and FAIL_PHASE, and set FAIL_VALID=1.
  - Later mismatches do not overwrite the capture.
- RST mid-run aborts immediately; all outputs take reset values. No partial results are retained.
- Drive outputs are registered (glitch-free). Only one input bit changes between consecutive phases of an arc.

Decomposition:
- Package oai222_arc_pkg holds:
  - pin index localparams;
  - the side-condition code LUT;
  - NUM_ARCS=54, NUM_PHASES=3;
  - the state enum {IDLE,RUN,DONE};
  - function vec_of(pin,cond,phase) returning the 6-bit drive vector;
  - function exp_of(phase) returning the expected ZN.
- One sub-module: sync2, a 2-flop synchroniser with async active-high reset, instantiated for ZN.

Test Plan:
- Ideal behavioural OAI222 model on ZN, SETTLE_CYCLES=4, START pulse → BUSY 1 for 810 edges; DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN stuck-at-0 → ERR_CNT=108, FAIL_ARC=0, FAIL_PHASE=0, PASS=0.
- ZN stuck-at-1 → ERR_CNT=54, FAIL_ARC=0, FAIL_PHASE=1.
- Faulty model ignoring B2, i.e. ZN=!((A1|A2)&B1&(C1|C2)) → ERR_CNT=21, FAIL_ARC=0, FAIL_PHASE=1. Also check the drive sequence for arc 13 (pin A2, cond 4): phase 1 vector is A1=0, A2=1, B1=1, B2=0, C1=1, C2=0.
- RST asserted 300 edges into a run → on the same edge A1..C2=0, BUSY=0, DONE=0, ERR_CNT=0; a new START then completes a full 810-edge run.
- START re-pulsed while BUSY → no effect, DONE at edge 810. START again in DONE → ERR_CNT/FAIL_VALID cleared and a new run begins.
